// File: rtl/jpeg_cone_pkg.sv
// Shared constants and the bitwise JPEG control-cone function for jpeg_cone_pipe.
package jpeg_cone_pkg;

  localparam int unsigned LANES_DEF  = 8;
  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned CONE_MAX_W = 64;

  typedef logic [CONE_MAX_W-1:0] cone_vec_t;

  // Lane-generic cone: callers widen operands to CONE_MAX_W and truncate the result.
  function automatic cone_vec_t jpeg_cone_f(input cone_vec_t n0, input cone_vec_t n1,
                                            input cone_vec_t n2, input cone_vec_t n3,
                                            input cone_vec_t n4);
    return n0 ^ (~n4 & ~(n2 | (n3 & ~n1)));
  endfunction

endpackage

// File: rtl/jpeg_cone_pipe_if.sv
// Valid/ready input and output channels of jpeg_cone_pipe.
interface jpeg_cone_pipe_if
  import jpeg_cone_pkg::*;
#(
  parameter int unsigned LANES = LANES_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [LANES-1:0] in_n0;
  logic [LANES-1:0] in_n1;
  logic [LANES-1:0] in_n2;
  logic [LANES-1:0] in_n3;
  logic [LANES-1:0] in_n4;
  logic             out_valid;
  logic             out_ready;
  logic [LANES-1:0] out_y;

  // Producer/consumer side, as seen by the environment.
  modport master (
    output in_valid, in_n0, in_n1, in_n2, in_n3, in_n4, out_ready,
    input  in_ready, out_valid, out_y
  );

  // Pipeline side.
  modport slave (
    input  in_valid, in_n0, in_n1, in_n2, in_n3, in_n4, out_ready,
    output in_ready, out_valid, out_y
  );

endinterface

// File: rtl/jpeg_cone_popcnt.sv
// Combinational population count of one output beat, feeding the ones counter.
module jpeg_cone_popcnt
  import jpeg_cone_pkg::*;
#(
  parameter int unsigned LANES = LANES_DEF,
  parameter int unsigned PC_W  = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0] i_vec,
  output logic [PC_W-1:0]  o_cnt_c
);

  always_comb begin
    o_cnt_c = '0;
    for (int i = 0; i < LANES; i++) begin
      o_cnt_c = o_cnt_c + PC_W'(i_vec[i]);
    end
  end

endmodule

// File: rtl/jpeg_cone_pipe.sv
// Two-stage valid/ready pipeline evaluating the JPEG control cone per lane.
// JPEG_CONE_CNT_EN adds a saturating counter of set output bits (cnt_clr/cnt_q).
module jpeg_cone_pipe
  import jpeg_cone_pkg::*;
#(
  parameter int unsigned LANES = LANES_DEF
`ifdef JPEG_CONE_CNT_EN
  ,
  parameter int unsigned CNT_W = CNT_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst,
  jpeg_cone_pipe_if.slave  s_bus
`ifdef JPEG_CONE_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_q
`endif
);

  logic             r_s1_valid;
  logic [LANES-1:0] r_g;
  logic [LANES-1:0] r_n4;
  logic [LANES-1:0] r_n0;
  logic             r_s2_valid;
  logic [LANES-1:0] r_y;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_in_ready;
  logic             w_in_fire;
  cone_vec_t        w_cone;
  logic [LANES-1:0] w_y;

  assign w_s2_adv   = ~r_s2_valid | s_bus.out_ready;
  assign w_s1_adv   = r_s1_valid & w_s2_adv;
  assign w_in_ready = ~r_s1_valid | w_s2_adv;
  assign w_in_fire  = s_bus.in_valid & w_in_ready;

  // S1 has already folded n1..n3 into g, so the cone sees n1=n3=0 and n2=g.
  assign w_cone = jpeg_cone_f(CONE_MAX_W'(r_n0), '0, CONE_MAX_W'(r_g), '0, CONE_MAX_W'(r_n4));
  assign w_y    = LANES'(w_cone);

  // Stage 1: data loads only on an accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_g        <= '0;
      r_n4       <= '0;
      r_n0       <= '0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_g        <= s_bus.in_n2 | (s_bus.in_n3 & ~s_bus.in_n1);
      r_n4       <= s_bus.in_n4;
      r_n0       <= s_bus.in_n0;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: output register, drains on consumer handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_y        <= '0;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_y        <= w_y;
    end else if (s_bus.out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign s_bus.in_ready  = w_in_ready;
  assign s_bus.out_valid = r_s2_valid;
  assign s_bus.out_y     = r_y;

`ifdef JPEG_CONE_CNT_EN
  localparam int unsigned PC_W  = $clog2(LANES + 1);
  localparam int unsigned SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

  logic [PC_W-1:0]  w_pc;
  logic [SUM_W-1:0] w_sum;
  logic             w_out_fire;
  logic [CNT_W-1:0] r_cnt;

  jpeg_cone_popcnt #(
    .LANES (LANES),
    .PC_W  (PC_W)
  ) u_popcnt (
    .i_vec   (r_y),
    .o_cnt_c (w_pc)
  );

  assign w_out_fire = r_s2_valid & s_bus.out_ready;
  assign w_sum      = SUM_W'(r_cnt) + SUM_W'(w_pc);

  // Saturating ones counter; clear beats a concurrent increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_out_fire) begin
      r_cnt <= (w_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : CNT_W'(w_sum);
    end
  end

  assign cnt_q = r_cnt;
`endif

endmodule

// File: tb/tb_jpeg_cone_pipe.sv
// Scoreboard bench for jpeg_cone_pipe (LANES=4); counter checks when JPEG_CONE_CNT_EN is defined.
module tb_jpeg_cone_pipe;

  localparam int unsigned LANES = 4;
`ifdef JPEG_CONE_CNT_EN
  localparam int unsigned CNT_W = 3;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_q;
  int               m_cnt;
`endif

  logic clk;
  logic rst;

  jpeg_cone_pipe_if #(.LANES(LANES)) bus ();

  jpeg_cone_pipe #(
    .LANES (LANES)
`ifdef JPEG_CONE_CNT_EN
    ,
    .CNT_W (CNT_W)
`endif
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .s_bus (bus)
`ifdef JPEG_CONE_CNT_EN
    ,
    .cnt_clr (cnt_clr),
    .cnt_q   (cnt_q)
`endif
  );

  int               checks   = 0;
  int               failures = 0;
  int               pops     = 0;
  logic [LANES-1:0] sb[$];
  logic [LANES-1:0] exp_cur;
  logic [LANES-1:0] mon_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference cone written as a per-lane decision on the operands.
  function automatic logic [LANES-1:0] model(input logic [LANES-1:0] n0, input logic [LANES-1:0] n1,
                                             input logic [LANES-1:0] n2, input logic [LANES-1:0] n3,
                                             input logic [LANES-1:0] n4);
    logic [LANES-1:0] y;
    for (int i = 0; i < LANES; i++) begin
      if (n4[i] || n2[i] || (n3[i] && !n1[i])) y[i] = n0[i];
      else                                     y[i] = !n0[i];
    end
    return y;
  endfunction

  function automatic int popc(input logic [LANES-1:0] v);
    int s = 0;
    for (int i = 0; i < LANES; i++) s += int'(v[i]);
    return s;
  endfunction

  // Expected value enters the scoreboard when the beat is about to be accepted.
  always @(negedge clk) begin
    if (!rst && bus.in_valid && bus.in_ready) sb.push_back(exp_cur);
  end

  // Monitor: pop and compare on every output handshake.
  always @(negedge clk) begin
    if (rst) begin
`ifdef JPEG_CONE_CNT_EN
      m_cnt = 0;
`endif
    end else begin
`ifdef JPEG_CONE_CNT_EN
      chk("cnt_q", 32'(cnt_q), 32'(m_cnt));
`endif
      if (bus.out_valid && bus.out_ready) begin
        mon_exp = '0;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got out_y %0h expected no beat at %0t", bus.out_y, $time);
        end else begin
          mon_exp = sb.pop_front();
          chk("out_y", 32'(bus.out_y), 32'(mon_exp));
          pops++;
        end
`ifdef JPEG_CONE_CNT_EN
        if (!cnt_clr) m_cnt = (m_cnt + popc(mon_exp) > CNT_MAX) ? CNT_MAX : m_cnt + popc(mon_exp);
`endif
      end
`ifdef JPEG_CONE_CNT_EN
      if (cnt_clr) m_cnt = 0;
`endif
    end
  end

  task automatic drive(input logic [LANES-1:0] n0, input logic [LANES-1:0] n1,
                       input logic [LANES-1:0] n2, input logic [LANES-1:0] n3,
                       input logic [LANES-1:0] n4, input logic [LANES-1:0] e);
    bus.in_n0    = n0;
    bus.in_n1    = n1;
    bus.in_n2    = n2;
    bus.in_n3    = n3;
    bus.in_n4    = n4;
    exp_cur      = e;
    bus.in_valid = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [LANES-1:0] n0, input logic [LANES-1:0] n1,
                      input logic [LANES-1:0] n2, input logic [LANES-1:0] n3,
                      input logic [LANES-1:0] n4, input logic [LANES-1:0] e,
                      output int stalls);
    drive(n0, n1, n2, n3, n4, e);
    stalls = 0;
    @(negedge clk);
    while (!bus.in_ready && stalls < 50) begin
      @(negedge clk);
      stalls++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int st;
    int stall_sum;
    int p0;
    logic [4:0] cb;
    logic [LANES-1:0] v0, v1, v2, v3, v4;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_n0     = '0;
    bus.in_n1     = '0;
    bus.in_n2     = '0;
    bus.in_n3     = '0;
    bus.in_n4     = '0;
    bus.out_ready = 1'b1;
    exp_cur       = '0;
`ifdef JPEG_CONE_CNT_EN
    cnt_clr = 1'b0;
    m_cnt   = 0;
`endif

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_y", 32'(bus.out_y), 32'd0);
`ifdef JPEG_CONE_CNT_EN
    chk("rst_cnt_q", 32'(cnt_q), 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;

    // Latency: all-zero operands give all-ones after two edges
    drive('0, '0, '0, '0, '0, 4'b1111);
    @(negedge clk);
    chk("lat_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("lat_edge1_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("lat_edge2_out_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_edge2_out_y", 32'(bus.out_y), 32'hf);
`ifdef JPEG_CONE_CNT_EN
    @(negedge clk);
    chk("cnt_after_first", 32'(cnt_q), 32'd4);
`endif
    @(posedge clk);
    #1;

    // Directed vectors with hand-computed results
    send(4'b1010, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0010, st);
    send(4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0101, st);
    send(4'b0011, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0011, st);
    send(4'b0011, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1100, st);
    send(4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, st);
    wait_drain();

    // All 32 operand combinations, streamed back-to-back
    p0 = pops;
    stall_sum = 0;
    for (int c = 0; c < 32; c++) begin
      for (int i = 0; i < LANES; i++) begin
        cb = 5'(c + i * 8);
        v0[i] = cb[0];
        v1[i] = cb[1];
        v2[i] = cb[2];
        v3[i] = cb[3];
        v4[i] = cb[4];
      end
      send(v0, v1, v2, v3, v4, model(v0, v1, v2, v3, v4), st);
      stall_sum += st;
    end
    wait_drain();
    chk("exh_stalls", 32'(stall_sum), 32'd0);
    chk("exh_pops", 32'(pops - p0), 32'd32);

    // Backpressure: three beats offered, only two fit
    p0 = pops;
    bus.out_ready = 1'b0;
    send(4'b1100, '0, '0, '0, '0, 4'b0011, st);
    send(4'b0110, '0, '0, '0, '0, 4'b1001, st);
    drive(4'b0001, '0, '0, '0, '0, 4'b1110);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_y_stable", 32'(bus.out_y), 32'h3);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rel_shift_out_valid", 32'(bus.out_valid), 32'd1);
    chk("rel_shift_out_y", 32'(bus.out_y), 32'h9);
    wait_drain();
    chk("bp_pops", 32'(pops - p0), 32'd3);

    // Asynchronous reset with both stages full
    bus.out_ready = 1'b0;
    send(4'b0000, '0, '0, '0, '0, 4'b1111, st);
    send(4'b0000, '0, '0, '0, '0, 4'b1111, st);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef JPEG_CONE_CNT_EN
    chk("arst_cnt_q", 32'(cnt_q), 32'd0);
`endif
    sb.delete();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;

`ifdef JPEG_CONE_CNT_EN
    // Saturation at 2^CNT_W-1, then clear against a concurrent handshake
    for (int k = 0; k < 3; k++) send('0, '0, '0, '0, '0, 4'b1111, st);
    wait_drain();
    @(negedge clk);
    chk("cnt_sat", 32'(cnt_q), 32'd7);
    @(posedge clk);
    #1;
    send('0, '0, '0, '0, '0, 4'b1111, st);
    @(posedge clk);
    #1 cnt_clr = 1'b1;
    @(negedge clk);
    chk("clr_concurrent_out_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    @(negedge clk);
    chk("cnt_clr_wins", 32'(cnt_q), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
